// File: rtl/pc_fetch.sv
// pc_fetch: single-outstanding instruction fetch FSM with a one-entry skid register.
// Optional PC_MISALIGN_CHK_EN registers a one-cycle misalign_o pulse on misaligned redirects.
module pc_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_i,
   input  logic        branch_flag_i,
   input  logic [31:0] branch_addr_i,
   output logic        ibus_req_o,
   output logic [31:0] ibus_addr_o,
   input  logic        ibus_gnt_i,
   input  logic        ibus_rvalid_i,
   input  logic [31:0] ibus_rdata_i,
   output logic [31:0] if_pc,
   output logic [31:0] if_inst,
   output logic        if_valid,
   output logic        misalign_o
);
   typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, DROP} state_e;
   state_e state_q;
   logic [31:0] pc_q, if_pc_q, if_inst_q, skid_pc_q, skid_inst_q, tgt;
   logic if_valid_q, hs, free, take, pop;
   assign ibus_req_o = state_q == REQ && (!stall_i || !if_valid_q);
   assign ibus_addr_o = ibus_req_o ? pc_q : 32'h0;
   assign hs = ibus_req_o && ibus_gnt_i;
   assign free = !if_valid_q || !stall_i;
   assign tgt = branch_addr_i & ~32'h3;
   assign take = state_q == WAIT && ibus_rvalid_i && free;
   assign pop = state_q == HOLD && !stall_i;
   assign if_pc = if_pc_q;
   assign if_inst = if_inst_q;
   assign if_valid = if_valid_q;
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         pc_q        <= RESET_PC;
         if_pc_q     <= 32'h0;
         if_inst_q   <= 32'h0;
         if_valid_q  <= 1'b0;
         skid_pc_q   <= 32'h0;
         skid_inst_q <= 32'h0;
      end else if (branch_flag_i) begin
         // a response still owed by the bus must be swallowed before refetching
         state_q     <= (hs || ((state_q == WAIT || state_q == DROP) && !ibus_rvalid_i)) ? DROP : REQ;
         pc_q        <= tgt;
         if_valid_q  <= 1'b0;
         if_inst_q   <= 32'h0;
         skid_pc_q   <= 32'h0;
         skid_inst_q <= 32'h0;
      end else begin
         case (state_q)
            IDLE: state_q <= REQ;
            REQ:  if (hs) state_q <= WAIT;
            WAIT: if (ibus_rvalid_i) begin
               state_q     <= free ? REQ : HOLD;
               pc_q        <= pc_q + 32'd4;
               skid_pc_q   <= pc_q;
               skid_inst_q <= ibus_rdata_i;
            end
            HOLD: if (!stall_i) state_q <= REQ;
            DROP: if (ibus_rvalid_i) state_q <= REQ;
            default: state_q <= IDLE;
         endcase
         if (take) begin
            if_pc_q    <= pc_q;
            if_inst_q  <= ibus_rdata_i;
            if_valid_q <= 1'b1;
         end else if (pop) begin
            if_pc_q    <= skid_pc_q;
            if_inst_q  <= skid_inst_q;
            if_valid_q <= 1'b1;
         end else if (!stall_i) begin
            if_valid_q <= 1'b0;
            if_inst_q  <= 32'h0;
         end
      end
   end
`ifdef PC_MISALIGN_CHK_EN
   logic misalign_q;
   always_ff @(posedge clk) misalign_q <= rst ? 1'b0 : branch_flag_i && |branch_addr_i[1:0];
   assign misalign_o = misalign_q;
`else
   assign misalign_o = 1'b0;
`endif
endmodule
